// File: rtl/cu_mul_iter.sv
// Iterative radix-2 shift-add multiplier; returns the low product word and an overflow flag.
// Latency: start edge E0, one multiplier bit per unstalled edge E1..E(W); done the cycle after E(W).
// Backpressure: ps_mul_stall freezes all state; start is ignored while busy, with no queueing.
//
// Ports:
//   clk_exe, rst_n           execute clock, async active-low reset
//   ps_mul_start/_sgn/_stall  start request, signed-mode select (latched with start), stall
//   xb_mul_dtx / xb_mul_dty   multiplicand / multiplier from the crossbar
//   mul_xb_dt, mul_ps_ovf     product low half and overflow, held until the next DONE entry
//   mul_ps_busy, mul_ps_done  state == RUN / state == DONE
module cu_mul_iter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_exe,
  input  logic                  rst_n,
  input  logic                  ps_mul_start,
  input  logic                  ps_mul_sgn,
  input  logic                  ps_mul_stall,
  input  logic [DATA_WIDTH-1:0] xb_mul_dtx,
  input  logic [DATA_WIDTH-1:0] xb_mul_dty,
  output logic [DATA_WIDTH-1:0] mul_xb_dt,
  output logic                  mul_ps_busy,
  output logic                  mul_ps_done,
  output logic                  mul_ps_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0]  CNT_ONE  = 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [2*W-1:0] ACC_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [2*W-1:0]   mcand_q,  mcand_d;   // multiplicand magnitude, shifted left each step
  logic [W-1:0]     mplier_q, mplier_d;  // multiplier magnitude, shifted right each step
  logic [2*W-1:0]   acc_q,    acc_d;
  logic             neg_q,    neg_d;     // result sign
  logic             sgn_q,    sgn_d;     // operation was signed (selects overflow rule)
  logic [W-1:0]     dt_q,     dt_d;
  logic             ovf_q,    ovf_d;

  logic             load;
  logic             last_step;
  logic [W-1:0]     mag_x;
  logic [W-1:0]     mag_y;
  logic [2*W-1:0]   addend;
  logic [2*W-1:0]   acc_sum;
  logic [2*W-1:0]   prod;
  logic [W:0]       sgn_bits;

  // State register and datapath flops.
  always_ff @(posedge clk_exe or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      dt_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      dt_q     <= dt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Start is honoured from IDLE and from DONE (back-to-back), never from RUN.
  assign load      = !ps_mul_stall && ps_mul_start && (state_q != RUN);
  assign last_step = (cnt_q == CNT_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!ps_mul_stall) begin
      unique case (state_q)
        IDLE:    if (ps_mul_start) state_d = RUN;
        RUN:     if (last_step)    state_d = DONE;
        DONE:    state_d = ps_mul_start ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, shift-add step, final sign fix-up and overflow.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    dt_d     = dt_q;
    ovf_d    = ovf_q;

    // The most-negative value negates to itself, which read unsigned is its magnitude.
    mag_x = (ps_mul_sgn && xb_mul_dtx[W-1]) ? W'(-xb_mul_dtx) : xb_mul_dtx;
    mag_y = (ps_mul_sgn && xb_mul_dty[W-1]) ? W'(-xb_mul_dty) : xb_mul_dty;

    addend   = mplier_q[0] ? mcand_q : '0;
    acc_sum  = acc_q + addend;
    prod     = neg_q ? (~acc_sum + ACC_ONE) : acc_sum;
    sgn_bits = prod[2*W-1:W-1];

    if (load) begin
      cnt_d    = '0;
      mcand_d  = {{W{1'b0}}, mag_x};
      mplier_d = mag_y;
      acc_d    = '0;
      neg_d    = ps_mul_sgn & (xb_mul_dtx[W-1] ^ xb_mul_dty[W-1]);
      sgn_d    = ps_mul_sgn;
    end else if (!ps_mul_stall && state_q == RUN) begin
      cnt_d    = cnt_q + CNT_ONE;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_sum;
      // Result registers are written on the edge that enters DONE.
      if (last_step) begin
        dt_d  = prod[W-1:0];
        ovf_d = sgn_q ? !((&sgn_bits) || !(|sgn_bits))
                      : (|prod[2*W-1:W]);
      end
    end
  end

  // Outputs.
  always_comb begin
    mul_ps_busy = (state_q == RUN);
    mul_ps_done = (state_q == DONE);
    mul_xb_dt   = dt_q;
    mul_ps_ovf  = ovf_q;
  end

endmodule
